// File: rtl/draw_background_cfg.sv
// draw_background_cfg: background/border pixel generator with frame-synchronous reconfiguration
// Timing signals ride a LATENCY-deep pipeline alongside the computed colour.
module draw_background_cfg #(
    parameter int          H_ACTIVE       = 800,
    parameter int          V_ACTIVE       = 600,
    parameter int          BORDER_W       = 1,
    parameter int          LATENCY        = 1,
    parameter int          BLINK_FRAMES   = 30,
    parameter logic [11:0] BG_DEFAULT     = 12'h888,
    parameter logic [11:0] BORDER_DEFAULT = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [11:0] cfg_bg_rgb,
    input  logic [11:0] cfg_border_rgb,
    input  logic        cfg_blink,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);
    localparam int          FW    = $clog2(BLINK_FRAMES) + 1;
    localparam logic [10:0] BW    = 11'(BORDER_W);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE - BORDER_W);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE - BORDER_W);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } stage_t;

    stage_t          pipe_q [LATENCY];
    stage_t          s0_d;
    logic [11:0]     bg_q, border_q, pbg_q, pborder_q;
    logic            blink_q, pblink_q, full_q, phase_q, vblnk_q;
    logic [FW-1:0]   cnt_q;
    logic            in_border, fb, accept, commit;

    always_comb begin
        in_border = vcount_in < BW || vcount_in >= V_LIM || hcount_in < BW || hcount_in >= H_LIM;
        s0_d = '{hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
                 (hblnk_in | vblnk_in) ? 12'h000 :
                 (in_border && !(blink_q && phase_q)) ? border_q : bg_q};
        fb     = vblnk_in & ~vblnk_q;
        accept = cfg_valid & ~full_q;
        // full_q is sampled before this edge, so a word accepted at an fb waits for the next one
        commit = fb & full_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q    <= '{default: '0};
            bg_q      <= BG_DEFAULT;
            border_q  <= BORDER_DEFAULT;
            blink_q   <= 1'b0;
            pbg_q     <= '0;
            pborder_q <= '0;
            pblink_q  <= 1'b0;
            full_q    <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            vblnk_q   <= 1'b0;
        end else begin
            pipe_q[0] <= s0_d;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            vblnk_q <= vblnk_in;
            if (accept) begin
                full_q    <= 1'b1;
                pbg_q     <= cfg_bg_rgb;
                pborder_q <= cfg_border_rgb;
                pblink_q  <= cfg_blink;
            end
            if (commit) begin
                bg_q     <= pbg_q;
                border_q <= pborder_q;
                blink_q  <= pblink_q;
                full_q   <= 1'b0;
                cnt_q    <= '0;
                phase_q  <= 1'b0;
            end else if (fb) begin
                if (cnt_q == FW'(BLINK_FRAMES - 1)) begin
                    cnt_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign cfg_ready  = ~full_q;
    assign hcount_out = pipe_q[LATENCY-1].hcount;
    assign vcount_out = pipe_q[LATENCY-1].vcount;
    assign hsync_out  = pipe_q[LATENCY-1].hsync;
    assign hblnk_out  = pipe_q[LATENCY-1].hblnk;
    assign vsync_out  = pipe_q[LATENCY-1].vsync;
    assign vblnk_out  = pipe_q[LATENCY-1].vblnk;
    assign rgb_out    = pipe_q[LATENCY-1].rgb;
endmodule

// File: tb/tb_draw_background_cfg.sv
// tb_draw_background_cfg: directed checks of colour, latency, cfg handshake, blink and reset
module tb_draw_background_cfg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic        cfg_valid = 1'b0, cfg_blink = 1'b0;
    logic [11:0] cfg_bg_rgb = '0, cfg_border_rgb = '0;
    logic        cfg_ready;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    int          checks = 0, failures = 0;

    draw_background_cfg #(
        .H_ACTIVE(800), .V_ACTIVE(600), .BORDER_W(3), .LATENCY(2), .BLINK_FRAMES(2),
        .BG_DEFAULT(12'h888), .BORDER_DEFAULT(12'hFFF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_bg_rgb(cfg_bg_rgb), .cfg_border_rgb(cfg_border_rgb), .cfg_blink(cfg_blink),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic px(input int h, input int v, input logic hb, input logic vb,
                      input logic hs = 1'b0, input logic vs = 1'b0);
        hcount_in = 11'(h); vcount_in = 11'(v);
        hblnk_in = hb; vblnk_in = vb; hsync_in = hs; vsync_in = vs;
        @(posedge clk); #1;
    endtask

    task automatic show(input int h, input int v, input logic [11:0] exp, input string tag);
        px(h, v, 1'b0, 1'b0);
        px(h, v, 1'b0, 1'b0);
        chk(tag, rgb_out, exp);
    endtask

    task automatic fb();
        px(0, 600, 1'b1, 1'b1);
    endtask

    task automatic offer(input logic [11:0] bg, input logic [11:0] bd, input logic bl);
        cfg_valid = 1'b1; cfg_bg_rgb = bg; cfg_border_rgb = bd; cfg_blink = bl;
        px(400, 300, 1'b0, 1'b0);
        cfg_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_h"}, 32'(hcount_out), 0);
        chk({tag, "_v"}, 32'(vcount_out), 0);
        chk({tag, "_sync"}, {hsync_out, hblnk_out, vsync_out, vblnk_out}, 0);
        chk({tag, "_rgb"}, 32'(rgb_out), 0);
        chk({tag, "_ready"}, 32'(cfg_ready), 1);
    endtask

    initial begin
        px(5, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        px(5, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_reset("rst");
        rst_n = 1'b1;
        show(100, 100, 12'h888, "interior_after_rst");

        show(2, 50, 12'hFFF, "left_border");
        show(3, 50, 12'h888, "left_inner");
        show(797, 599, 12'hFFF, "right_bottom");
        show(796, 300, 12'h888, "right_inner");
        show(400, 597, 12'hFFF, "bottom_border");
        show(400, 596, 12'h888, "bottom_inner");
        px(0, 50, 1'b1, 1'b0);
        px(0, 50, 1'b1, 1'b0);
        chk("hblank_black", rgb_out, 12'h000);
        chk("hblank_pass", hblnk_out, 1'b1);

        px(500, 500, 1'b0, 1'b0);
        px(500, 500, 1'b0, 1'b0);
        px(123, 45, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lat_not_yet", hcount_out, 11'd500);
        px(7, 8, 1'b0, 1'b0);
        chk("lat_h", hcount_out, 11'd123);
        chk("lat_v", vcount_out, 11'd45);
        chk("lat_syncs", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 4'b1100);
        chk("lat_rgb", rgb_out, 12'h888);
        px(7, 8, 1'b0, 1'b0);
        chk("lat_next_h", hcount_out, 11'd7);
        chk("lat_next_sync", hsync_out, 1'b0);

        offer(12'h00F, 12'hF00, 1'b0);
        chk("cfg_ready_drop", cfg_ready, 1'b0);
        show(400, 300, 12'h888, "midframe_bg_old");
        show(0, 300, 12'hFFF, "midframe_bd_old");
        offer(12'h0F0, 12'h0F0, 1'b0);
        chk("ignored_busy", cfg_ready, 1'b0);
        fb();
        chk("vblank_pass", vblnk_out, 1'b0);
        chk("cfg_ready_back", cfg_ready, 1'b1);
        show(400, 300, 12'h00F, "commit_bg");
        show(0, 300, 12'hF00, "commit_bd");

        cfg_valid = 1'b1; cfg_bg_rgb = 12'h0F0; cfg_border_rgb = 12'h0FF; cfg_blink = 1'b0;
        fb();
        cfg_valid = 1'b0;
        chk("same_edge_ready", cfg_ready, 1'b0);
        show(400, 300, 12'h00F, "same_edge_bg_old");
        show(1, 300, 12'hF00, "same_edge_bd_old");
        fb();
        chk("same_edge_ready_back", cfg_ready, 1'b1);
        show(400, 300, 12'h0F0, "same_edge_bg_new");
        show(799, 300, 12'h0FF, "same_edge_bd_new");

        offer(12'h123, 12'hABC, 1'b1);
        fb();
        show(0, 10, 12'hABC, "blink_f0");
        fb();
        show(0, 10, 12'hABC, "blink_f1");
        fb();
        show(0, 10, 12'h123, "blink_f2");
        show(400, 300, 12'h123, "blink_f2_bg");
        fb();
        show(0, 10, 12'h123, "blink_f3");
        fb();
        show(0, 10, 12'hABC, "blink_f4");
        fb();
        show(0, 10, 12'hABC, "blink_f5");
        offer(12'h123, 12'hABC, 1'b1);
        fb();
        show(0, 10, 12'hABC, "restart_f0");
        fb();
        show(0, 10, 12'hABC, "restart_f1");
        fb();
        show(0, 10, 12'h123, "restart_f2");

        offer(12'h555, 12'h666, 1'b0);
        chk("pend_full", cfg_ready, 1'b0);
        rst_n = 1'b0;
        px(5, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        px(5, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_reset("rst2");
        rst_n = 1'b1;
        show(400, 300, 12'h888, "rst2_bg");
        show(0, 300, 12'hFFF, "rst2_bd");
        fb();
        show(400, 300, 12'h888, "rst2_dropped_bg");
        show(0, 300, 12'hFFF, "rst2_dropped_bd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
